// File: rtl/riscv_pkg.sv
// Shared load/store encodings and FSM state type for the LSU.
// is_misaligned() is used only when LSU_MISALIGN_EXC_EN is defined.
package riscv_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_BUSY,
      LSU_DONE
   } lsu_state_t;

   // Undefined sizes fall into the word case, matching the lane logic.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      case (size)
         LDST_B, LDST_BU: return 1'b0;
         LDST_H, LDST_HU: return addr_lo[0];
         default:         return (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for the LSU: byte enables, store-data replication and
// load-data sign/zero extension, all from size and the two low address bits.
module lsu_data_align
   import riscv_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wd,
   input  logic [31:0] rd,
   output logic [3:0]  be,
   output logic [31:0] wd_rep,
   output logic [31:0] rd_ext
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_byte = rd[{addr_lo, 3'b000} +: 8];
   assign rd_half = addr_lo[1] ? rd[31:16] : rd[15:0];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      be     = 4'b1111;
      wd_rep = wd;
      rd_ext = rd;
      case (size)
         LDST_B, LDST_BU: begin
            be     = 4'b0001 << addr_lo;
            wd_rep = {4{wd[7:0]}};
            rd_ext = (size == LDST_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
         end
         LDST_H, LDST_HU: begin
            be     = 4'b0011 << {addr_lo[1], 1'b0};
            wd_rep = {2{wd[15:0]}};
            rd_ext = (size == LDST_H) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
         end
         default: begin
            be     = 4'b1111;
            wd_rep = wd;
            rd_ext = rd;
         end
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: IDLE -> BUSY (request held until ready) -> DONE (one cycle).
// Optional LSU_MISALIGN_EXC_EN rejects misaligned H/W accesses with a misaligned_o pulse.
module lsu_controller
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [2:0]        core_size_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wd_i,
   output logic [DATA_W-1:0] core_rd_o,
   output logic              core_stall_o,
   output logic              misaligned_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wd_o,
   input  logic [DATA_W-1:0] mem_rd_i,
   input  logic              mem_ready_i
);

   lsu_state_t        state, state_nxt;
   logic              capture;
   logic              misalign_exc;

   logic              lat_we;
   logic [2:0]        lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wd;

   logic [3:0]        al_be;
   logic [DATA_W-1:0] al_wd;
   logic [DATA_W-1:0] al_rd;

`ifdef LSU_MISALIGN_EXC_EN
   assign misalign_exc = is_misaligned(core_size_i, core_addr_i[1:0]);
`else
   assign misalign_exc = 1'b0;
`endif

   lsu_data_align u_align (
      .size    (lat_size),
      .addr_lo (lat_addr[1:0]),
      .wd      (lat_wd),
      .rd      (mem_rd_i),
      .be      (al_be),
      .wd_rep  (al_wd),
      .rd_ext  (al_rd)
   );

   always_ff @(posedge clk_i) begin
      // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
      if (!rst_ni) begin
         state     <= LSU_IDLE;
         core_rd_o <= '0;
         lat_we    <= 1'b0;
         lat_size  <= '0;
         lat_addr  <= '0;
         lat_wd    <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            lat_we   <= core_we_i;
            lat_size <= core_size_i;
            lat_addr <= core_addr_i;
            lat_wd   <= core_wd_i;
         end
         if (state == LSU_BUSY && mem_ready_i && !lat_we) begin
            core_rd_o <= al_rd;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      capture      = 1'b0;
      core_stall_o = 1'b0;
      misaligned_o = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_be_o     = '0;
      mem_addr_o   = '0;
      mem_wd_o     = '0;
      case (state)
         LSU_IDLE: begin
            if (core_req_i) begin
               if (misalign_exc) begin
                  misaligned_o = 1'b1;
               end else begin
                  core_stall_o = 1'b1;
                  capture      = 1'b1;
                  state_nxt    = LSU_BUSY;
               end
            end
         end
         LSU_BUSY: begin
            core_stall_o = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = lat_we;
            mem_be_o     = al_be;
            mem_addr_o   = lat_addr;
            mem_wd_o     = al_wd;
            if (mem_ready_i) state_nxt = LSU_DONE;
         end
         LSU_DONE: state_nxt = LSU_IDLE;
         default:  state_nxt = LSU_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed cases then randomized accesses
// compared against an arithmetic lane model. Honours LSU_MISALIGN_EXC_EN.
module tb_lsu_controller;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        misaligned_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] exp_rd  = 32'h0;

`ifdef LSU_MISALIGN_EXC_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   always #5 clk_i = ~clk_i;

   lsu_controller dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_size_i  (core_size_i),
      .core_addr_i  (core_addr_i),
      .core_wd_i    (core_wd_i),
      .core_rd_o    (core_rd_o),
      .core_stall_o (core_stall_o),
      .misaligned_o (misaligned_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wd_o     (mem_wd_o),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_i  (mem_ready_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: access width in bytes; lanes follow from aligning the offset down to it.
   function automatic int size_bytes(input logic [2:0] s);
      case (s)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic int lane_off(input logic [2:0] s, input logic [31:0] addr);
      int n = size_bytes(s);
      return (int'(addr[1:0]) / n) * n;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] s, input logic [31:0] addr);
      int n = size_bytes(s);
      return 4'(((1 << n) - 1) << lane_off(s, addr));
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] s, input logic [31:0] wd);
      logic [31:0] r;
      int n = size_bytes(s);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [2:0] s, input logic [31:0] addr, input logic [31:0] rd);
      int n = size_bytes(s);
      longint v = longint'(rd >> (8 * lane_off(s, addr)));
      if (n < 4) begin
         v = v & ((longint'(1) << (8 * n)) - 1);
         if ((s == 3'd0 || s == 3'd1) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
      end
      return 32'(v);
   endfunction

   task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
      int          n    = size_bytes(sz);
      bit          mis  = MIS_EN && (int'(addr[1:0]) % n != 0);
      logic [3:0]  be_e = model_be(sz, addr);
      logic [31:0] wd_e = model_wd(sz, wd);
      logic [31:0] rd_e = model_rd(sz, addr, rd);
      core_req_i  = 1'b1;
      core_we_i   = we;
      core_size_i = sz;
      core_addr_i = addr;
      core_wd_i   = wd;
      mem_ready_i = 1'b0;
      @(negedge clk_i);
      if (mis) begin
         check("mis_pulse", 32'(misaligned_o), 32'd1);
         check("mis_stall", 32'(core_stall_o), 32'd0);
         check("mis_req",   32'(mem_req_o), 32'd0);
         @(posedge clk_i); #1;
         core_req_i  = 1'b0;
         mem_ready_i = 1'b1;
         @(negedge clk_i);
         check("mis_after_pulse", 32'(misaligned_o), 32'd0);
         check("mis_after_req",   32'(mem_req_o), 32'd0);
         check("mis_after_stall", 32'(core_stall_o), 32'd0);
         @(posedge clk_i); #1;
         mem_ready_i = 1'b0;
         return;
      end
      check("req_cycle_stall", 32'(core_stall_o), 32'd1);
      check("req_cycle_memreq", 32'(mem_req_o), 32'd0);
      check("req_cycle_mis", 32'(misaligned_o), 32'd0);
      @(posedge clk_i); #1;
      // Scramble the core-side inputs: the access must run from latched fields.
      core_req_i  = 1'b0;
      core_we_i   = ~we;
      core_size_i = 3'($urandom);
      core_addr_i = $urandom;
      core_wd_i   = $urandom;
      for (int k = 0; k <= waits; k++) begin
         mem_ready_i = (k == waits);
         mem_rd_i    = (k == waits) ? rd : $urandom;
         @(negedge clk_i);
         check("busy_req",   32'(mem_req_o), 32'd1);
         check("busy_stall", 32'(core_stall_o), 32'd1);
         check("busy_we",    32'(mem_we_o), 32'(we));
         check("busy_be",    32'(mem_be_o), 32'(be_e));
         check("busy_addr",  mem_addr_o, addr);
         check("busy_wd",    mem_wd_o, wd_e);
         @(posedge clk_i); #1;
      end
      mem_ready_i = 1'b0;
      mem_rd_i    = $urandom;
      if (!we) exp_rd = rd_e;
      @(negedge clk_i);
      check("done_stall", 32'(core_stall_o), 32'd0);
      check("done_req",   32'(mem_req_o), 32'd0);
      check("done_rd",    core_rd_o, exp_rd);
      @(posedge clk_i); #1;
   endtask

   initial begin
      logic [2:0] sizes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      rst_ni      = 1'b0;
      core_req_i  = 1'b0;
      core_we_i   = 1'b0;
      core_size_i = 3'd0;
      core_addr_i = 32'h0;
      core_wd_i   = 32'h0;
      mem_rd_i    = 32'h0;
      mem_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_rd",    core_rd_o, 32'h0);
      check("rst_stall", 32'(core_stall_o), 32'd0);
      check("rst_req",   32'(mem_req_o), 32'd0);
      check("rst_be",    32'(mem_be_o), 32'd0);
      check("rst_mis",   32'(misaligned_o), 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // LB at 0x103: lane 3 byte 0x80 sign-extends.
      access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0);
      check("lb_value", core_rd_o, 32'hFFFF_FF80);
      // SH at 0x206 with three wait cycles.
      access(1'b1, 3'd1, 32'h0000_0206, 32'h1234_ABCD, 32'h0, 3);
      // LHU at 0x2.
      access(1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'h8001_0000, 0);
      check("lhu_value", core_rd_o, 32'h0000_8001);
      // LW then SW back-to-back; SW must leave core_rd_o alone.
      access(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0);
      access(1'b1, 3'd2, 32'h0000_0044, 32'h5555_AAAA, 32'h1111_2222, 0);
      check("sw_keeps_rd", core_rd_o, 32'hDEAD_BEEF);
      // LW at 0x101: trapped with the feature, issued as a full word without it.
      access(1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0BAD_F00D, 1);

      // Reset while BUSY abandons the access.
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_size_i = 3'd2;
      core_addr_i = 32'h0000_0080;
      @(posedge clk_i); #1;
      core_req_i = 1'b0;
      rst_ni     = 1'b0;
      @(negedge clk_i);
      check("busy_before_rst", 32'(mem_req_o), 32'd1);
      @(posedge clk_i); #1;
      rst_ni      = 1'b1;
      mem_ready_i = 1'b1;
      exp_rd      = 32'h0;
      @(negedge clk_i);
      check("midrst_req",   32'(mem_req_o), 32'd0);
      check("midrst_stall", 32'(core_stall_o), 32'd0);
      check("midrst_rd",    core_rd_o, 32'h0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("midrst_idle_req", 32'(mem_req_o), 32'd0);
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0;

      for (int t = 0; t < 60; t++) begin
         access(1'($urandom), sizes[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
